// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory responder.
// Defines the response bundle carried by the read pipeline and the FIFO.
package imem_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [INSTRUCTION_WIDTH-1:0] IMEM_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instruction;
        logic                         error;
    } imem_response_t;

endpackage

// File: rtl/imem_response_fifo.sv
// Response buffer: synchronous FIFO of imem_response_t, async active-low reset.
// Ports: clock, reset_n, push/push_data, pop/pop_data (head), full, empty.
module imem_response_fifo
    import imem_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           push,
    input  imem_response_t push_data,
    input  logic           pop,
    output imem_response_t pop_data,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    imem_response_t   entries_q [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full, a push and a pop hit the same slot; the pop sees the
    // old head because the write only lands on the edge.
    always_ff @(posedge clock) begin
        if (push) entries_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = entries_q[rd_ptr_q];
    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);

endmodule

// File: rtl/instruction_memory_responder.sv
// Instruction-fetch responder: word memory, fixed-latency read pipe, credit-
// controlled response FIFO, load port. Optional error check: IMEM_ERROR_CHECK_EN.
module instruction_memory_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int LATENCY      = 2,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         request_valid,
    output logic                         request_ready,
    input  logic [ADDRESS_WIDTH-1:0]     request_address,
    output logic                         response_valid,
    input  logic                         response_ready,
    output logic [INSTRUCTION_WIDTH-1:0] response_instruction,
    output logic                         response_error,
    input  logic                         load_enable,
    input  logic [ADDRESS_WIDTH-1:0]     load_address,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIMIT =
        ADDRESS_WIDTH'(DEPTH_WORDS);

    logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    logic [LATENCY-1:0] stage_valid_q, stage_valid_d;
    imem_response_t     stage_data_q [LATENCY];
    imem_response_t     stage_data_d [LATENCY];

    imem_response_t   read_resp;
    logic [IDX_W-1:0] fetch_index;
    logic [IDX_W-1:0] load_index;
    logic             load_in_range;

    imem_response_t fifo_head;
    logic           fifo_full;
    logic           fifo_empty;

    assign request_ready = (outstanding_q < CNT_MAX) && reset_n;
    assign accept        = request_valid && request_ready;
    assign pop           = response_valid && response_ready;

    // Credits cover both in-flight pipeline entries and buffered words,
    // so the pipeline never needs to stall.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    assign fetch_index = request_address[IDX_W+1:2];
    assign load_index  = load_address[IDX_W+1:2];
    assign load_in_range =
        ({2'b00, load_address[ADDRESS_WIDTH-1:2]} < DEPTH_LIMIT);

`ifdef IMEM_ERROR_CHECK_EN
    logic fetch_error;

    assign fetch_error =
        (request_address[1:0] != 2'b00) ||
        ({2'b00, request_address[ADDRESS_WIDTH-1:2]} >= DEPTH_LIMIT);

    always_comb begin
        read_resp = '0;
        if (fetch_error) begin
            read_resp.instruction = IMEM_NOP;
            read_resp.error       = 1'b1;
        end else begin
            read_resp.instruction = mem[fetch_index];
        end
    end

    assign response_error = response_valid && fifo_head.error;
`else
    logic unused_fetch_bits;

    assign unused_fetch_bits = ^{
        request_address[1:0],
        request_address[ADDRESS_WIDTH-1:IDX_W+2],
        fifo_head.error
    };

    always_comb begin
        read_resp             = '0;
        read_resp.instruction = mem[fetch_index];
    end

    assign response_error = 1'b0;
`endif

    logic unused_load_bits;
    assign unused_load_bits = ^load_address[1:0];

    always_comb begin
        stage_valid_d[0] = accept;
        stage_data_d[0]  = read_resp;
        for (int i = 1; i < LATENCY; i++) begin
            stage_valid_d[i] = stage_valid_q[i-1];
            stage_data_d[i]  = stage_data_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
            stage_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            stage_valid_q <= stage_valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data_q[i] <= stage_data_d[i];
            end
        end
    end

    // Not reset; the same-edge read above sees the old word.
    always_ff @(posedge clock) begin
        if (load_enable && load_in_range) begin
            mem[load_index] <= load_data;
        end
    end

    imem_response_fifo #(
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (stage_valid_q[LATENCY-1]),
        .push_data(stage_data_q[LATENCY-1]),
        .pop      (pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    logic unused_full;
    assign unused_full = fifo_full;

    assign response_valid = !fifo_empty;
    assign response_instruction =
        response_valid ? fifo_head.instruction : '0;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench for instruction_memory_responder.
// Scoreboard of expected responses, checked on every response pop.
module tb_instruction_memory_responder;

    localparam int DW  = 256;
    localparam int LAT = 2;
    localparam int BD  = 4;
    localparam int IW  = $clog2(DW);

    logic        clock;
    logic        reset_n;
    logic        request_valid;
    logic        request_ready;
    logic [31:0] request_address;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_instruction;
    logic        response_error;
    logic        load_enable;
    logic [31:0] load_address;
    logic [31:0] load_data;

    instruction_memory_responder #(
        .DEPTH_WORDS (DW),
        .LATENCY     (LAT),
        .BUFFER_DEPTH(BD)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .request_valid       (request_valid),
        .request_ready       (request_ready),
        .request_address     (request_address),
        .response_valid      (response_valid),
        .response_ready      (response_ready),
        .response_instruction(response_instruction),
        .response_error      (response_error),
        .load_enable         (load_enable),
        .load_address        (load_address),
        .load_data           (load_data)
    );

    typedef struct {
        logic [32:0] resp;
        int          acc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model_mem [DW];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        lat_chk  = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model_fetch(input logic [31:0] a);
`ifdef IMEM_ERROR_CHECK_EN
        if (a[1:0] != 2'b00 || {2'b00, a[31:2]} >= 32'(DW))
            return {1'b1, 32'h0000_0013};
        return {1'b0, model_mem[a[IW+1:2]]};
`else
        return {1'b0, model_mem[a[IW+1:2]]};
`endif
    endfunction

    // Expectations are taken before the model applies a same-edge load.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (request_valid && request_ready)
                exp_q.push_back('{resp: model_fetch(request_address),
                                  acc: cyc + 1});
            if (response_valid && response_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", {31'd0, response_error,
                                   response_instruction},
                          {31'd0, e.resp});
                    if (lat_chk)
                        check("latency", 64'(cyc - e.acc), 64'(LAT));
                end
            end
        end
        if (load_enable && {2'b00, load_address[31:2]} < 32'(DW))
            model_mem[load_address[IW+1:2]] = load_data;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        int n = 0;
        request_valid   = 1'b1;
        request_address = a;
        while (!request_ready && n < 20) begin
            tick;
            n++;
        end
        if (!request_ready) check("fetch_timeout", 64'd0, 64'd1);
        tick;
        request_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int   n;
        logic acc;

        reset_n         = 1'b1;
        request_valid   = 1'b0;
        request_address = '0;
        response_ready  = 1'b1;
        load_enable     = 1'b0;
        load_address    = '0;
        load_data       = '0;
        #1 reset_n = 1'b0;
        repeat (3) tick;
        check("rst_ready", 64'(request_ready), 64'd0);
        check("rst_valid", 64'(response_valid), 64'd0);
        check("rst_instr", 64'(response_instruction), 64'd0);
        check("rst_error", 64'(response_error), 64'd0);
        reset_n = 1'b1;
        #1;
        check("rel_ready", 64'(request_ready), 64'd1);

        for (int i = 0; i < 16; i++) begin
            load_enable  = 1'b1;
            load_address = 32'(i * 4);
            load_data    = (i < 3) ? 32'h1111_1111 * 32'(i + 1)
                                   : 32'hC0DE_0000 + 32'(i);
            tick;
        end
        load_enable = 1'b0;

        // back-to-back fetches, latency and throughput
        lat_chk         = 1'b1;
        request_valid   = 1'b1;
        request_address = 32'h0;
        tick;
        request_address = 32'h4;
        tick;
        request_address = 32'h8;
        tick;
        request_valid = 1'b0;
        drain(20);
        lat_chk = 1'b0;

        // backpressure fills the buffer
        response_ready  = 1'b0;
        request_valid   = 1'b1;
        request_address = 32'h20;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            acc = request_ready;
            tick;
            if (acc) begin
                n++;
                request_address = request_address + 32'd4;
            end
        end
        request_valid = 1'b0;
        check("accepted", 64'(n), 64'(BD));
        check("full_ready", 64'(request_ready), 64'd0);
        tick;
        tick;
        check("hold_valid", 64'(response_valid), 64'd1);
        check("hold_instr", 64'(response_instruction), 64'hC0DE_0008);
        response_ready = 1'b1;
        drain(20);
        tick;
        check("empty_after", 64'(response_valid), 64'd0);

        // error / wrap fetches
        fetch(32'h2);
        fetch(32'(4 * DW));
        drain(20);

        // same-edge load and fetch of one word
        load_enable     = 1'b1;
        load_address    = 32'h10;
        load_data       = 32'hAAAA_0000;
        request_valid   = 1'b1;
        request_address = 32'h10;
        tick;
        load_enable   = 1'b0;
        request_valid = 1'b0;
        fetch(32'h10);
        drain(20);
        check("rbw_model", 64'(model_mem[4]), 64'hAAAA_0000);

        // reset with one buffered word and two in flight
        response_ready = 1'b0;
        fetch(32'h0);
        repeat (LAT + 1) tick;
        request_valid   = 1'b1;
        request_address = 32'h4;
        tick;
        request_address = 32'h8;
        tick;
        request_valid = 1'b0;
        reset_n       = 1'b0;
        #1;
        check("mid_rst_valid", 64'(response_valid), 64'd0);
        check("mid_rst_ready", 64'(request_ready), 64'd0);
        check("mid_rst_instr", 64'(response_instruction), 64'd0);
        tick;
        tick;
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(request_ready), 64'd1);
        response_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("no_stale", 64'(response_valid), 64'd0);
        end
        fetch(32'h8);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
